// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchroniser, counter-based debouncer and a
// released/pressed/long classifier producing a level, one-cycle event pulses and a press count.
module button_debounce #(
  parameter int FREQ         = 27_000_000,
  parameter int DEBOUNCE_CYC = FREQ / 100,
  parameter int LONG_CYC     = FREQ,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       btn_i,
  output logic       pressed_o,
  output logic       press_o,
  output logic       release_o,
  output logic       long_o,
  output logic [7:0] count_o
);

  if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
    $error("button_debounce: DEBOUNCE_CYC must be >= 1");
  end
  if (LONG_CYC < 1) begin : g_bad_long
    $error("button_debounce: LONG_CYC must be >= 1");
  end

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int HW = $clog2(LONG_CYC + 1);
  localparam logic [DW-1:0] DcntLast = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HcntLast = HW'(LONG_CYC - 1);
  // Sync FFs reset to the released pad level so reset release never looks like a press.
  localparam logic PadIdle = ACTIVE_LOW;

  typedef enum logic [1:0] {
    StReleased,
    StPressed,
    StLong
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_q, long_d;
  logic [7:0]      count_q, count_d;

  logic            btn_s;
  logic            level;
  logic            accept;

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
  end

  assign btn_s = sync2_q ^ ACTIVE_LOW;
  assign level = (state_q != StReleased);

  // ---------------------------------------------------------------------------
  // Debounce: accept a change after DEBOUNCE_CYC consecutive differing cycles
  // ---------------------------------------------------------------------------
  always_comb begin
    dcnt_d = '0;
    accept = 1'b0;
    if (btn_s != level) begin
      if (dcnt_q == DcntLast) begin
        accept = 1'b1;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Classifier FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    count_d   = count_q;
    case (state_q)
      StReleased: begin
        if (accept) begin
          state_d = StPressed;
          press_d = 1'b1;
          count_d = count_q + 8'd1;
          hcnt_d  = '0;
        end
      end
      StPressed: begin
        // An accepted release takes priority over a long-press firing in the same cycle.
        if (accept) begin
          state_d   = StReleased;
          release_d = 1'b1;
        end else if (hcnt_q == HcntLast) begin
          state_d = StLong;
          long_d  = 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      StLong: begin
        if (accept) begin
          state_d   = StReleased;
          release_d = 1'b1;
        end
      end
      default: begin
        state_d = StReleased;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q   <= PadIdle;
      sync2_q   <= PadIdle;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      state_q   <= StReleased;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      count_q   <= count_d;
    end
  end

  assign pressed_o = level;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign count_o   = count_q;

  // ---------------------------------------------------------------------------
  // Event pulse properties
  // ---------------------------------------------------------------------------
  a_pulses_exclusive: assert property (@(posedge clk_i) disable iff (!rstn_i)
    $onehot0({press_q, release_q, long_q}));
  a_press_single: assert property (@(posedge clk_i) disable iff (!rstn_i)
    press_q |=> !press_q);
  a_release_single: assert property (@(posedge clk_i) disable iff (!rstn_i)
    release_q |=> !release_q);
  a_long_single: assert property (@(posedge clk_i) disable iff (!rstn_i)
    long_q |=> !long_q);

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: stimulus queues expected events, a monitor
// pops and compares them whenever the DUT pulses press_o, release_o or long_o.
module tb_button_debounce;

  localparam int DebCyc  = 4;
  localparam int LongCyc = 20;
  localparam int Lat     = 2 + DebCyc;

  typedef enum int {EvPress, EvRelease, EvLong} ev_e;
  typedef struct {
    ev_e        kind;
    int         at;
    logic [7:0] cnt;
    logic       lvl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn_i;
  logic       btn_i;
  logic       pressed_o;
  logic       press_o;
  logic       release_o;
  logic       long_o;
  logic [7:0] count_o;

  int         cyc = 0;
  int         nvec = 0;
  int         nerr = 0;
  logic [7:0] cnt_m = 8'd0;
  exp_t       q[$];

  button_debounce #(
    .FREQ        (27_000_000),
    .DEBOUNCE_CYC(DebCyc),
    .LONG_CYC    (LongCyc),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk_i    (clk),
    .rstn_i   (rstn_i),
    .btn_i    (btn_i),
    .pressed_o(pressed_o),
    .press_o  (press_o),
    .release_o(release_o),
    .long_o   (long_o),
    .count_o  (count_o)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input ev_e k, input int at, input logic [7:0] c, input logic l);
    exp_t e;
    e.kind = k;
    e.at   = at;
    e.cnt  = c;
    e.lvl  = l;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (q.size() != 0 && i < 300) begin
      tick(1);
      i++;
    end
    chk("events_outstanding", q.size(), 0);
    q.delete();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pressed_o"}, int'(pressed_o), 0);
    chk({tag, "_press_o"}, int'(press_o), 0);
    chk({tag, "_release_o"}, int'(release_o), 0);
    chk({tag, "_long_o"}, int'(long_o), 0);
    chk({tag, "_count_o"}, int'(count_o), int'(cnt_m));
  endtask

  // Press held for 'hold' cycles, then released and left idle for 'gap' cycles.
  task automatic do_press(input int hold, input int gap);
    int c;
    @(negedge clk);
    btn_i = 1'b0;
    c = cyc;
    cnt_m = cnt_m + 8'd1;
    push(EvPress, c + Lat, cnt_m, 1'b1);
    if (hold > LongCyc) push(EvLong, c + Lat + LongCyc, cnt_m, 1'b1);
    tick(hold);
    btn_i = 1'b1;
    push(EvRelease, c + hold + Lat, cnt_m, 1'b0);
    tick(gap);
  endtask

  task automatic bounce(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      btn_i = 1'b0;
      tick(3);
      btn_i = 1'b1;
      tick(3);
    end
  endtask

  // Monitor
  always @(negedge clk) begin : monitor
    int   n;
    ev_e  k;
    exp_t e;
    if (rstn_i === 1'b1 && (press_o || release_o || long_o)) begin
      n = int'(press_o) + int'(release_o) + int'(long_o);
      chk("pulses_per_event", n, 1);
      k = press_o ? EvPress : (release_o ? EvRelease : EvLong);
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", k, cyc);
      end else begin
        e = q.pop_front();
        chk("event_kind", int'(k), int'(e.kind));
        chk("event_cycle", cyc, e.at);
        chk("event_count_o", int'(count_o), int'(e.cnt));
        chk("event_pressed_o", int'(pressed_o), int'(e.lvl));
      end
    end
  end

  initial begin : watchdog
    #(60000 * 20);
    $display("FAIL watchdog: simulation did not finish, expected finish before cycle 60000");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int c;
    btn_i  = 1'b1;
    rstn_i = 1'b1;
    #1 rstn_i = 1'b0;

    // Reset and idle
    @(negedge clk);
    chk_idle("in_reset");
    tick(2);
    rstn_i = 1'b1;
    tick(50);
    chk_idle("idle50");

    // Clean press and release
    do_press(10, 12);
    drain();
    chk("clean_pressed_o", int'(pressed_o), 0);
    chk("clean_count_o", int'(count_o), 1);

    // Bounce rejection, then a real press after bouncing
    bounce(5);
    tick(10);
    chk_idle("after_bounce");
    bounce(3);
    do_press(10, 12);
    drain();
    chk("bounce_count_o", int'(count_o), int'(cnt_m));

    // Long press, short press, release on the long cycle, release one cycle later
    do_press(40, 12);
    do_press(10, 12);
    do_press(LongCyc, 12);
    do_press(LongCyc + 1, 12);
    drain();
    chk("long_count_o", int'(count_o), int'(cnt_m));

    // Counter wrap from a fresh reset
    @(negedge clk);
    rstn_i = 1'b0;
    cnt_m  = 8'd0;
    tick(2);
    rstn_i = 1'b1;
    tick(5);
    chk("wrap_start_count_o", int'(count_o), 0);
    for (int i = 0; i < 256; i++) do_press(8, 10);
    drain();
    chk("wrap_count_o", int'(count_o), int'(cnt_m));

    // Reset asserted while the button is held
    @(negedge clk);
    btn_i = 1'b0;
    c = cyc;
    cnt_m = cnt_m + 8'd1;
    push(EvPress, c + Lat, cnt_m, 1'b1);
    drain();
    chk("pre_reset_pressed_o", int'(pressed_o), 1);
    @(negedge clk);
    rstn_i = 1'b0;
    cnt_m  = 8'd0;
    #1;
    chk_idle("held_reset");
    tick(2);
    rstn_i = 1'b1;
    c = cyc;
    cnt_m = 8'd1;
    push(EvPress, c + Lat, cnt_m, 1'b1);
    drain();
    chk("post_reset_count_o", int'(count_o), 1);
    @(negedge clk);
    btn_i = 1'b1;
    push(EvRelease, cyc + Lat, cnt_m, 1'b0);
    drain();
    chk("final_pressed_o", int'(pressed_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
